// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared opcode, accumulator-select, ALU opcode, FSM state and
//                instruction-class definitions for the acc_sequencer block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

   // Instruction opcodes (instruction bits [7:4])
   localparam logic [3:0] OP_NOP = 4'h0;
   localparam logic [3:0] OP_LDI = 4'h1;
   localparam logic [3:0] OP_LDR = 4'h2;
   localparam logic [3:0] OP_STR = 4'h3;
   localparam logic [3:0] OP_ADD = 4'h4;
   localparam logic [3:0] OP_SUB = 4'h5;
   localparam logic [3:0] OP_AND = 4'h6;
   localparam logic [3:0] OP_OR  = 4'h7;
   localparam logic [3:0] OP_XOR = 4'h8;
   localparam logic [3:0] OP_NOT = 4'h9;
   localparam logic [3:0] OP_JMP = 4'hA;
   localparam logic [3:0] OP_JZ  = 4'hB;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Accumulator select codes
   localparam logic [1:0] SEL_REG = 2'b10;   // mux <- register (also the idle code)
   localparam logic [1:0] SEL_IMM = 2'b11;   // mux <- imm
   localparam logic [1:0] LD_MUX  = 2'b00;   // acc <- mux
   localparam logic [1:0] LD_ALU  = 2'b01;   // acc <- ALU

   // ALU opcodes
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_XOR = 3'b100;
   localparam logic [2:0] ALU_NOT = 3'b101;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_SELECT = 4'd2,
      ST_LOAD   = 4'd3,
      ST_EXEC   = 4'd4,
      ST_WRITE  = 4'd5,
      ST_FETCH2 = 4'd6,
      ST_TARGET = 4'd7,
      ST_HALT   = 4'd8
   } state_t;

   typedef enum logic [3:0] {
      CL_NOP = 4'd0,
      CL_LDI = 4'd1,
      CL_LDR = 4'd2,
      CL_STR = 4'd3,
      CL_ALU = 4'd4,
      CL_NOT = 4'd5,
      CL_JMP = 4'd6,
      CL_JZ  = 4'd7,
      CL_HLT = 4'd8,
      CL_ILL = 4'd9
   } iclass_t;

endpackage

`default_nettype wire

// File: rtl/instr_decoder.sv
// ============================================================================
//  Module      : instr_decoder
//  Description : Combinational opcode decode into instruction class and the
//                ALU opcode used by the EXEC step.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_decoder
   import ctrl_pkg::*;
(
   input  logic [3:0] i_opcode,
   output iclass_t    o_class,
   output logic [2:0] o_alu_op
);

   // Opcode to class / ALU operation map
   always_comb begin
      o_class  = CL_NOP;
      o_alu_op = ALU_ADD;
      case (i_opcode)
         OP_NOP: o_class = CL_NOP;
         OP_LDI: o_class = CL_LDI;
         OP_LDR: o_class = CL_LDR;
         OP_STR: o_class = CL_STR;
         OP_ADD: begin o_class = CL_ALU; o_alu_op = ALU_ADD; end
         OP_SUB: begin o_class = CL_ALU; o_alu_op = ALU_SUB; end
         OP_AND: begin o_class = CL_ALU; o_alu_op = ALU_AND; end
         OP_OR:  begin o_class = CL_ALU; o_alu_op = ALU_OR;  end
         OP_XOR: begin o_class = CL_ALU; o_alu_op = ALU_XOR; end
         OP_NOT: begin o_class = CL_NOT; o_alu_op = ALU_NOT; end
         OP_JMP: o_class = CL_JMP;
         OP_JZ:  o_class = CL_JZ;
         OP_HLT: o_class = CL_HLT;
         default: o_class = CL_ILL;   // C, D, E
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/acc_sequencer.sv
// ============================================================================
//  Module      : acc_sequencer
//  Description : Multi-cycle fetch/decode/execute sequencer driving the
//                accumulator, register-file and ALU controls of the 8-bit
//                processor. All control outputs are registered.
//  Config      : ACC_SEQ_ILLEGAL_TRAP_EN - when defined, opcodes C..E halt the
//                sequencer and set the sticky illegal flag; otherwise they
//                behave as NOP and illegal is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module acc_sequencer
   import ctrl_pkg::*;
#(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            clb,
   output logic [PC_W-1:0] imem_addr,
   input  logic [7:0]      imem_data,
   input  logic            acc_zero,
   output logic [1:0]      sel_acc,
   output logic            load_acc,
   output logic [3:0]      imm,
   output logic [3:0]      reg_addr,
   output logic            reg_we,
   output logic [2:0]      alu_op,
   output logic            halted,
   output logic            illegal
);

   state_t          r_state;
   logic [PC_W-1:0] r_pc;
   logic [7:0]      r_ir;
   logic [1:0]      r_sel_acc;
   logic            r_load_acc;
   logic [3:0]      r_imm;
   logic [3:0]      r_reg_addr;
   logic            r_reg_we;
   logic [2:0]      r_alu_op;
   logic            r_halted;

   logic [7:0]      w_instr;
   logic [3:0]      w_operand;
   iclass_t         w_class;
   logic [2:0]      w_alu_op;
   logic            w_taken;

   // In DECODE the instruction is still on the memory bus; afterwards use the latched copy
   assign w_instr   = (r_state == ST_DECODE) ? imem_data : r_ir;
   assign w_operand = w_instr[3:0];
   assign w_taken   = (w_class == CL_JMP) || acc_zero;

   instr_decoder u_instr_decoder (
      .i_opcode (w_instr[7:4]),
      .o_class  (w_class),
      .o_alu_op (w_alu_op)
   );

`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
   logic r_illegal;

   // Sticky illegal-opcode flag, cleared only by reset
   always_ff @(posedge clk or negedge clb) begin
      if (!clb)
         r_illegal <= 1'b0;
      else if (r_state == ST_DECODE && w_class == CL_ILL)
         r_illegal <= 1'b1;
   end

   assign illegal = r_illegal;
`else
   assign illegal = 1'b0;
`endif

   // Sequencer FSM; outputs are registered with the values of the state being entered
   always_ff @(posedge clk or negedge clb) begin
      if (!clb) begin
         r_state    <= ST_FETCH;
         r_pc       <= '0;
         r_ir       <= 8'h00;
         r_sel_acc  <= SEL_REG;
         r_load_acc <= 1'b0;
         r_imm      <= 4'h0;
         r_reg_addr <= 4'h0;
         r_reg_we   <= 1'b0;
         r_alu_op   <= ALU_ADD;
         r_halted   <= 1'b0;
      end else begin
         // idle values unless the next state drives them
         r_sel_acc  <= SEL_REG;
         r_load_acc <= 1'b0;
         r_imm      <= 4'h0;
         r_reg_addr <= 4'h0;
         r_reg_we   <= 1'b0;
         r_alu_op   <= ALU_ADD;
         case (r_state)
            ST_FETCH: r_state <= ST_DECODE;
            ST_DECODE: begin
               r_ir <= imem_data;
               r_pc <= r_pc + PC_W'(1);
               case (w_class)
                  CL_LDI: begin
                     r_state   <= ST_SELECT;
                     r_sel_acc <= SEL_IMM;
                     r_imm     <= w_operand;
                  end
                  CL_LDR, CL_ALU: begin
                     r_state    <= ST_SELECT;
                     r_sel_acc  <= SEL_REG;
                     r_reg_addr <= w_operand;
                  end
                  CL_NOT: begin
                     r_state    <= ST_EXEC;
                     r_sel_acc  <= LD_ALU;
                     r_load_acc <= 1'b1;
                     r_alu_op   <= w_alu_op;
                     r_reg_addr <= w_operand;
                  end
                  CL_STR: begin
                     r_state    <= ST_WRITE;
                     r_reg_we   <= 1'b1;
                     r_reg_addr <= w_operand;
                  end
                  CL_JMP, CL_JZ: r_state <= ST_FETCH2;
                  CL_HLT: begin
                     r_state  <= ST_HALT;
                     r_halted <= 1'b1;
                  end
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
                  CL_ILL: begin
                     r_state  <= ST_HALT;
                     r_halted <= 1'b1;
                  end
`else
                  CL_ILL: r_state <= ST_FETCH;
`endif
                  default: r_state <= ST_FETCH;
               endcase
            end
            ST_SELECT: begin
               if (w_class == CL_LDI || w_class == CL_LDR) begin
                  r_state    <= ST_LOAD;
                  r_sel_acc  <= LD_MUX;
                  r_load_acc <= 1'b1;
               end else begin
                  r_state    <= ST_EXEC;
                  r_sel_acc  <= LD_ALU;
                  r_load_acc <= 1'b1;
                  r_alu_op   <= w_alu_op;
                  r_reg_addr <= w_operand;
               end
            end
            ST_LOAD, ST_EXEC, ST_WRITE: r_state <= ST_FETCH;
            ST_FETCH2: r_state <= ST_TARGET;
            ST_TARGET: begin
               r_pc    <= w_taken ? PC_W'(imem_data) : r_pc + PC_W'(1);
               r_state <= ST_FETCH;
            end
            ST_HALT: r_state <= ST_HALT;
            default: r_state <= ST_FETCH;
         endcase
      end
   end

   assign imem_addr = r_pc;
   assign sel_acc   = r_sel_acc;
   assign load_acc  = r_load_acc;
   assign imm       = r_imm;
   assign reg_addr  = r_reg_addr;
   assign reg_we    = r_reg_we;
   assign alu_op    = r_alu_op;
   assign halted    = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_acc_sequencer.sv
// ============================================================================
//  Module      : tb_acc_sequencer
//  Description : Self-checking bench for acc_sequencer. An instruction-level
//                model expands each program into its expected per-cycle
//                output trace; directed programs add literal expectations.
//  Config      : ACC_SEQ_ILLEGAL_TRAP_EN selects the illegal-opcode behaviour
//                expected by the model and the directed checks.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_acc_sequencer;

   logic       clk;
   logic       clb;
   logic [7:0] imem_addr;
   logic [7:0] imem_data;
   logic       acc_zero;
   logic [1:0] sel_acc;
   logic       load_acc;
   logic [3:0] imm;
   logic [3:0] reg_addr;
   logic       reg_we;
   logic [2:0] alu_op;
   logic       halted;
   logic       illegal;

   logic [7:0]  mem [0:255];
   logic [24:0] expv [0:255];
   logic [24:0] obs [0:255];
   int          kk;
   int          total;
   int          bad;

   // field layout: addr[24:17] sel[16:15] ld[14] imm[13:10] ra[9:6] we[5] op[4:2] h[1] il[0]
   wire  [24:0] w_dut_vec = {imem_addr, sel_acc, load_acc, imm, reg_addr, reg_we, alu_op, halted, illegal};
   localparam logic [24:0] RST_VEC = {8'h00, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0};

   acc_sequencer #(.PC_W(8)) dut (
      .clk       (clk),
      .clb       (clb),
      .imem_addr (imem_addr),
      .imem_data (imem_data),
      .acc_zero  (acc_zero),
      .sel_acc   (sel_acc),
      .load_acc  (load_acc),
      .imm       (imm),
      .reg_addr  (reg_addr),
      .reg_we    (reg_we),
      .alu_op    (alu_op),
      .halted    (halted),
      .illegal   (illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // synchronous-read program memory
   always @(posedge clk) imem_data <= mem[imem_addr];

   function automatic logic [24:0] pk(input logic [7:0] a, input logic [1:0] s, input logic ld,
                                      input logic [3:0] im, input logic [3:0] ra, input logic we,
                                      input logic [2:0] op, input logic h, input logic il);
      return {a, s, ld, im, ra, we, op, h, il};
   endfunction

   function automatic void push(input logic [24:0] v);
      if (kk < 256) expv[kk] = v;
      kk++;
   endfunction

   function automatic logic [24:0] idle(input logic [7:0] a);
      return pk(a, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0);
   endfunction

   // Expand the program in mem into n cycles of expected outputs, one instruction at a time
   task automatic build(input int n, input bit az);
      logic [7:0] pc, nx, ins;
      logic [3:0] opc, opd;
      pc = 8'h00;
      kk = 0;
      while (kk < n) begin
         ins = mem[pc];
         opc = ins[7:4];
         opd = ins[3:0];
         nx  = pc + 8'd1;
         push(idle(pc));   // fetch
         push(idle(pc));   // decode
         case (opc)
            4'h0: ;
            4'h1: begin
               push(pk(nx, 2'b11, 1'b0, opd, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0));
               push(pk(nx, 2'b00, 1'b1, 4'h0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0));
            end
            4'h2: begin
               push(pk(nx, 2'b10, 1'b0, 4'h0, opd, 1'b0, 3'b000, 1'b0, 1'b0));
               push(pk(nx, 2'b00, 1'b1, 4'h0, 4'h0, 1'b0, 3'b000, 1'b0, 1'b0));
            end
            4'h3: push(pk(nx, 2'b10, 1'b0, 4'h0, opd, 1'b1, 3'b000, 1'b0, 1'b0));
            4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
               push(pk(nx, 2'b10, 1'b0, 4'h0, opd, 1'b0, 3'b000, 1'b0, 1'b0));
               push(pk(nx, 2'b01, 1'b1, 4'h0, opd, 1'b0, 3'(opc - 4'h4), 1'b0, 1'b0));
            end
            4'h9: push(pk(nx, 2'b01, 1'b1, 4'h0, opd, 1'b0, 3'b101, 1'b0, 1'b0));
            4'hA, 4'hB: begin
               push(idle(nx));   // target byte fetch
               push(idle(nx));   // target resolve
               nx = (opc == 4'hA || az) ? mem[nx] : nx + 8'd1;
            end
            4'hF: while (kk < n) push(pk(nx, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b0));
            default: begin
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
               while (kk < n) push(pk(nx, 2'b10, 1'b0, 4'h0, 4'h0, 1'b0, 3'b000, 1'b1, 1'b1));
`endif
            end
         endcase
         pc = nx;
      end
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%h want=%h", nm, got, want);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   // Reset, release and compare the DUT against the model trace every cycle
   task automatic run_prog(input int n, input bit az);
      build(n, az);
      acc_zero = az;
      clb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_values", 32'(w_dut_vec), 32'(RST_VEC));
      clb = 1'b1;
      #1;
      for (int i = 0; i < n; i++) begin
         obs[i] = w_dut_vec;
         total++;
         if (obs[i] !== expv[i]) begin
            bad++;
            $display("FAIL trace cyc=%0d got=%h want=%h", i, obs[i], expv[i]);
         end
         @(negedge clk);
         #1;
      end
   endtask

   initial begin
      int we_cnt, ld_cnt;
      logic [7:0] b;
      total    = 0;
      bad      = 0;
      clb      = 1'b0;
      acc_zero = 1'b0;
      clear_mem();

      // LDI A then HLT
      clear_mem(); mem[0] = 8'h1A; mem[1] = 8'hF0;
      run_prog(12, 1'b0);
      chk("model_ldi_imm", 32'(expv[2][13:10]), 32'hA);
      chk("model_halt_c6", 32'(expv[6][1]), 32'h1);
      chk("ldi_sel_imm", 32'({obs[2][16:15], obs[2][13:10]}), 32'h3A);
      chk("ldi_load", 32'({obs[3][16:15], obs[3][14]}), 32'h1);
      chk("hlt_not_yet_c5", 32'(obs[5][1]), 32'h0);
      chk("hlt_at_c6", 32'(obs[6][1]), 32'h1);

      // LDR 3, ADD 5, NOT
      clear_mem(); mem[0] = 8'h23; mem[1] = 8'h45; mem[2] = 8'h90;
      run_prog(14, 1'b0);
      chk("ldr_select", 32'({obs[2][16:15], obs[2][9:6]}), 32'h23);
      chk("ldr_load", 32'({obs[3][16:15], obs[3][14]}), 32'h1);
      chk("add_exec", 32'({obs[7][16:15], obs[7][14], obs[7][9:6], obs[7][4:2]}), 32'({2'b01, 1'b1, 4'h5, 3'b000}));
      chk("not_exec", 32'({obs[10][16:15], obs[10][14], obs[10][4:2]}), 32'({2'b01, 1'b1, 3'b101}));
      chk("after_not_fetch", 32'(obs[11][24:17]), 32'h03);

      // JZ taken / not taken
      clear_mem(); mem[0] = 8'hB0; mem[1] = 8'h40;
      run_prog(8, 1'b1);
      chk("jz_taken_pc", 32'(obs[4][24:17]), 32'h40);
      run_prog(8, 1'b0);
      chk("jz_not_taken_pc", 32'(obs[4][24:17]), 32'h02);

      // STR 7: one write strobe, no load
      clear_mem(); mem[0] = 8'h37;
      run_prog(20, 1'b0);
      we_cnt = 0; ld_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         we_cnt += int'(obs[i][5]);
         ld_cnt += int'(obs[i][14]);
      end
      chk("str_we_count", 32'(we_cnt), 32'd1);
      chk("str_no_load", 32'(ld_cnt), 32'd0);
      chk("str_reg_addr", 32'({obs[2][5], obs[2][9:6]}), 32'h17);

      // NOP at FF wraps to 00
      clear_mem(); mem[0] = 8'hA0; mem[1] = 8'hFF;
      run_prog(10, 1'b0);
      chk("jmp_to_ff", 32'(obs[4][24:17]), 32'hFF);
      chk("nop_wrap_00", 32'(obs[6][24:17]), 32'h00);

      // JZ with its target byte at FF, not taken
      clear_mem(); mem[0] = 8'hA0; mem[1] = 8'hFE; mem[8'hFE] = 8'hB0; mem[8'hFF] = 8'h12;
      run_prog(12, 1'b0);
      chk("jz_tgt_fetch_ff", 32'(obs[6][24:17]), 32'hFF);
      chk("jz_wrap_00", 32'(obs[8][24:17]), 32'h00);

      // illegal opcode C0
      clear_mem(); mem[0] = 8'hC0;
      run_prog(8, 1'b0);
`ifdef ACC_SEQ_ILLEGAL_TRAP_EN
      chk("illegal_trap", 32'({obs[2][1], obs[2][0]}), 32'h3);
      chk("illegal_sticky", 32'(obs[7][0]), 32'h1);
`else
      chk("illegal_as_nop", 32'(obs[2][24:17]), 32'h01);
      chk("illegal_tied_low", 32'({obs[2][1], obs[7][0]}), 32'h0);
`endif

      // asynchronous reset during EXEC
      clear_mem(); mem[0] = 8'h90;
      clb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      clb = 1'b1;
      #1;
      @(negedge clk); #1;
      @(negedge clk); #1;
      chk("exec_before_reset", 32'({sel_acc, load_acc}), 32'h3);
      clb = 1'b0;
      #1;
      chk("async_reset_exec", 32'(w_dut_vec), 32'(RST_VEC));

      // randomized programs
      for (int r = 0; r < 10; r++) begin
         for (int i = 0; i < 256; i++) begin
            b = 8'($urandom);
            if (b[7:4] == 4'hF && $urandom_range(0, 7) != 0) b[7:4] = 4'h1;
            mem[i] = b;
         end
         run_prog(200, 1'($urandom_range(0, 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/acc_sequencer.md
# acc_sequencer

Multi-cycle control sequencer for the 8-bit processor. It fetches 8-bit instructions from program memory, decodes them, and drives the accumulator's select and load controls (`selAcc`, `loadAcc`, `imm`). It also drives the register-file address and write enable and the ALU opcode. It is the initiating end of the accumulator control interface and sits between program memory and the accumulator/ALU/register-file datapath.

## Interface
- `PC_W`, 8: program-counter and instruction-memory address width.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clb`  in  1  reset, asynchronous, active-low.
- `imem_addr`  out  PC_W  instruction-memory address; equals `pc`.
- `imem_data`  in  8  instruction byte, valid exactly one cycle after `imem_addr` is driven (synchronous read).
- `acc_zero`  in  1  accumulator-equals-zero flag from the datapath.
- `sel_acc`  out  2  accumulator select (to `selAcc`):
  - 10: mux ← register.
  - 11: mux ← imm.
  - 00: acc ← mux.
  - 01: acc ← ALU.
- `load_acc`  out  1  accumulator load strobe (to `loadAcc`).
- `imm`  out  4  immediate operand (to `imm`).
- `reg_addr`  out  4  register-file index.
- `reg_we`  out  1  register-file write enable (writes acc into `reg_addr`).
- `alu_op`  out  3  ALU opcode: ADD 000, SUB 001, AND 010, OR 011, XOR 100, NOT 101.
- `halted`  out  1  high while in HALT.
- `illegal`  out  1  sticky illegal-opcode flag.

## Operation
- Instruction format: `opcode[7:4]`, `operand[3:0]`.
- Opcodes:
  - 0 NOP.
  - 1 LDI (acc ← imm).
  - 2 LDR (acc ← R[n]).
  - 3 STR (R[n] ← acc).
  - 4 ADD, 5 SUB, 6 AND, 7 OR, 8 XOR: acc ← acc op R[n].
  - 9 NOT.
  - A JMP, B JZ: two-byte instructions; the second byte is the target address.
  - F HLT.
  - C, D, E: illegal.
- States: FETCH, DECODE, SELECT, LOAD, EXEC, WRITE, FETCH2, TARGET, HALT.
- FETCH: `imem_addr` = `pc`. Next state: DECODE.
- DECODE: latch `ir` ← `imem_data`; `pc` ← `pc`+1 (wraps FF→00). Next state by opcode:
  - NOP → FETCH.
  - LDI, LDR, ALU-reg ops → SELECT.
  - NOT → EXEC.
  - STR → WRITE.
  - JMP, JZ → FETCH2.
  - HLT → HALT.
- SELECT:
  - LDI: `sel_acc`=11, `imm`=operand.
  - LDR and ALU-reg ops: `sel_acc`=10, `reg_addr`=operand.
  - Next state: LOAD for LDI/LDR, EXEC for ALU ops.
- LOAD: `sel_acc`=00, `load_acc`=1, one cycle. Next state: FETCH.
- EXEC: `sel_acc`=01, `load_acc`=1, `alu_op` from opcode, `reg_addr` held at operand. Next state: FETCH.
- WRITE: `reg_we`=1, `reg_addr`=operand, one cycle. Next state: FETCH.
- FETCH2: `imem_addr` = `pc` (target byte). Next state: TARGET.
- TARGET:
  - Taken (JMP, or JZ with `acc_zero`=1, sampled in this cycle): `pc` ← `imem_data`.
  - Not taken: `pc` ← `pc`+1 (wrap).
  - Next state: FETCH.
- HALT: all strobes low; `halted`=1; leaves only on reset.
- Idle values whenever a state does not drive them: `sel_acc`=10 (acc untouched), `load_acc`=0, `reg_we`=0, `alu_op`=000, `imm`=0, `reg_addr`=0.
- `load_acc` and `reg_we` are never high in the same cycle.

## Timing
- Outputs are registered (decoded from the registered state and `ir`).
- Reset values: state FETCH, `pc`=00, `imem_addr`=00, `sel_acc`=10, `load_acc`=0, `imm`=0, `reg_addr`=0, `reg_we`=0, `alu_op`=000, `halted`=0, `illegal`=0.
- Cycles per instruction:
  - NOP: 2.
  - NOT, STR: 3.
  - LDI, LDR, ALU-reg: 4.
  - JMP, JZ: 4.
  - HLT: 2, then parked.
- First fetch occurs in the first cycle after `clb` deasserts.
- Reset asserted mid-instruction: all outputs return to reset values immediately (asynchronously); the partial instruction is abandoned; no strobe is completed.
- JZ target byte at address FF: the fetch reads FF, and a not-taken `pc` wraps to 00.

## Configuration
- `ACC_SEQ_ILLEGAL_TRAP_EN`:
  - Defined: opcodes C–E go to HALT from DECODE, and `illegal` sets to 1 and stays set until reset.
  - Undefined: opcodes C–E execute as NOP (2 cycles), and `illegal` is tied to 0.

## Structure
- Shared package `ctrl_pkg` holds:
  - The 4-bit opcode constants.
  - The `sel_acc` codes (SEL_REG, SEL_IMM, LD_MUX, LD_ALU).
  - The 3-bit ALU opcode constants.
  - The state enumeration.
- One sub-module, `instr_decoder`: combinational map from opcode to instruction class (nop/ldi/ldr/str/alu/not/jmp/jz/hlt/illegal) and `alu_op`. The FSM instantiates it.

## Test plan
- Reset, then memory `{00:1A, 01:F0}` → SELECT cycle shows `sel_acc`=11 with `imm`=A; next cycle `sel_acc`=00, `load_acc`=1; `halted`=1 at cycle 6.
- `{00:23, 01:45, 02:90}` → LDR: `reg_addr`=3 with `sel_acc`=10, then load. ADD: EXEC cycle has `alu_op`=000, `sel_acc`=01, `reg_addr`=5. NOT: EXEC at cycle 3 after its fetch.
- `{00:B0, 01:40}` with `acc_zero`=1 → `pc`=40 at the next FETCH. With `acc_zero`=0 → `pc`=02.
- `{00:37}` → exactly one cycle with `reg_we`=1, `reg_addr`=7; `load_acc` stays 0.
- `pc` at FF holding NOP → next fetch address 00.
- Opcode C0 → with the macro: HALT, `illegal`=1. Without the macro: treated as NOP, next fetch at 01.
- Additional reset scenario: assert `clb` during EXEC → outputs return to reset values immediately; `pc`=00.
